// File: rtl/yctrl_fsm.sv
// rtl/yctrl_fsm.sv - multi-cycle control FSM for the yPC/yIF/yID/yEX/yDM/yWB datapath
// Registered control outputs describe the state currently occupied; next outputs are decoded from next state and IR.
module yctrl_fsm #(
  parameter int CNT_W           = 16,
  parameter int ENTRY_CYCLES    = 1,
  parameter int MAX_INS         = 0,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ins,
  input  logic             zero,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg,
  output logic             isBranch,
  output logic             isJump,
  output logic             INT,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             ins_done,
  output logic             halted,
  output logic [CNT_W-1:0] ins_count
);

  typedef enum logic [2:0] {
    S_ENTRY, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LW, C_SW, C_BEQ, C_JAL, C_ILL
  } cls_t;

  localparam int EW = $clog2(ENTRY_CYCLES + 2);

  state_t          state, nstate, retire_to;
  cls_t            cls;
  logic [EW-1:0]   ecnt;
  logic [6:0]      ir_opc, cw_opc;
  logic [2:0]      ir_f3, cw_f3;
  logic            ir_b30, cw_b30;
  logic [2:0]      aop;
  logic            nlast, in_seq, in_ex;
  logic [CNT_W-1:0] cnt_inc;
  logic            unused_bits;

  // zero is consumed by yPC directly; only opcode, funct3 and bit 30 matter here.
  assign unused_bits = ^{zero, ins[31], ins[29:15], ins[11:7]};

  always_comb begin
    // In FETCH the word being captured this edge drives the DECODE outputs.
    cw_opc  = (state == S_FETCH) ? ins[6:0]   : ir_opc;
    cw_f3   = (state == S_FETCH) ? ins[14:12] : ir_f3;
    cw_b30  = (state == S_FETCH) ? ins[30]    : ir_b30;
    cls     = C_ILL;
    aop     = 3'b000;
    case (cw_opc)
      7'h33: begin
        case (cw_f3)
          3'b110:  begin cls = C_R; aop = 3'b001; end
          3'b111:  begin cls = C_R; aop = 3'b000; end
          3'b000:  begin cls = C_R; aop = cw_b30 ? 3'b110 : 3'b010; end
          default: begin cls = C_ILL; aop = 3'b000; end
        endcase
      end
      7'h13:   begin cls = C_I;   aop = 3'b010; end
      7'h03:   begin cls = C_LW;  aop = 3'b010; end
      7'h23:   begin cls = C_SW;  aop = 3'b010; end
      7'h63:   begin cls = C_BEQ; aop = 3'b110; end
      7'h6F:   begin cls = C_JAL; aop = 3'b000; end
      default: begin cls = C_ILL; aop = 3'b000; end
    endcase

    cnt_inc   = (ins_count == '1) ? ins_count : ins_count + 1'b1;
    retire_to = ((MAX_INS != 0) && (cnt_inc == CNT_W'(MAX_INS))) ? S_HALT : S_FETCH;

    nstate = state;
    case (state)
      S_ENTRY:  nstate = (ecnt < EW'(ENTRY_CYCLES)) ? S_ENTRY : S_FETCH;
      S_FETCH:  nstate = S_DECODE;
      S_DECODE: begin
        if (ins_done)                                      nstate = retire_to;
        else if (cls == C_ILL && HALT_ON_ILLEGAL != 0)     nstate = S_HALT;
        else                                               nstate = S_EXEC;
      end
      S_EXEC: begin
        if (ins_done)                                      nstate = retire_to;
        else if (cls == C_LW || cls == C_SW)               nstate = S_MEM;
        else                                               nstate = S_WB;
      end
      S_MEM:    nstate = ins_done ? retire_to : S_WB;
      S_WB:     nstate = retire_to;
      S_HALT:   nstate = S_HALT;
      default:  nstate = S_ENTRY;
    endcase

    nlast  = (nstate == S_DECODE && cls == C_ILL && HALT_ON_ILLEGAL == 0) ||
             (nstate == S_EXEC && (cls == C_BEQ || cls == C_JAL)) ||
             (nstate == S_MEM && cls == C_SW) ||
             (nstate == S_WB);
    in_seq = (nstate == S_DECODE) || (nstate == S_EXEC) || (nstate == S_MEM) || (nstate == S_WB);
    in_ex  = (nstate == S_EXEC) || (nstate == S_MEM) || (nstate == S_WB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ENTRY;
      ecnt      <= '0;
      ir_opc    <= '0;
      ir_f3     <= '0;
      ir_b30    <= 1'b0;
      RegWrite  <= 1'b0;
      ALUSrc    <= 1'b0;
      op        <= 3'b000;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      Mem2Reg   <= 1'b0;
      isBranch  <= 1'b0;
      isJump    <= 1'b0;
      INT       <= 1'b0;
      IRWrite   <= 1'b0;
      PCWrite   <= 1'b0;
      ins_done  <= 1'b0;
      halted    <= 1'b0;
      ins_count <= '0;
    end else begin
      state <= nstate;
      if (state == S_ENTRY && nstate == S_ENTRY)
        ecnt <= ecnt + 1'b1;
      if (state == S_FETCH) begin
        ir_opc <= ins[6:0];
        ir_f3  <= ins[14:12];
        ir_b30 <= ins[30];
      end
      if (ins_done)
        ins_count <= cnt_inc;
      RegWrite <= (nstate == S_WB);
      ALUSrc   <= in_ex && (cls == C_I || cls == C_LW || cls == C_SW);
      op       <= in_seq ? aop : 3'b000;
      MemRead  <= (nstate == S_MEM || nstate == S_WB) && cls == C_LW;
      MemWrite <= (nstate == S_MEM) && cls == C_SW;
      Mem2Reg  <= (nstate == S_WB) && cls == C_LW;
      isBranch <= (nstate == S_EXEC) && cls == C_BEQ;
      isJump   <= (nstate == S_EXEC) && cls == C_JAL;
      INT      <= (nstate == S_ENTRY);
      IRWrite  <= (nstate == S_FETCH);
      PCWrite  <= (nstate == S_ENTRY) || nlast;
      ins_done <= nlast;
      halted   <= (nstate == S_HALT);
    end
  end

endmodule

// File: doc/yctrl_fsm.md
Name: yctrl_fsm

Overview:
Multi-cycle control unit that issues control signals to the existing datapath stages: yPC, yIF, yID, yEX, yDM and yWB. It latches each fetched instruction and steps through FETCH/DECODE/EXEC/MEM/WB states. In each state it drives RegWrite, ALUSrc, op, MemRead, MemWrite, Mem2Reg, isBranch, isJump and INT, so the bench no longer hand-decodes opcodes. It also counts retired instructions and halts on an illegal opcode or at an instruction limit.

Parameters:
CNT_W, 16, width of the retired-instruction counter.
ENTRY_CYCLES, 1, number of cycles INT stays high after reset (PC loads entryPoint).
MAX_INS, 0, halt after this many retired instructions; 0 = unlimited.
HALT_ON_ILLEGAL, 1, 1 = illegal opcode enters HALT; 0 = treat it as a NOP and retire it.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
ins  in  32  instruction from yIF; sampled on the last edge of FETCH.
zero  in  1  ALU zero flag; passed through only (yPC consumes it).
RegWrite  out  1  register-file write enable.
ALUSrc  out  1  1 = immediate operand, 0 = rd2.
op  out  3  ALU operation: 010 add, 110 sub, 001 or, 000 and.
MemRead  out  1  data-memory read enable.
MemWrite  out  1  data-memory write enable.
Mem2Reg  out  1  write-back source select: 1 = memOut.
isBranch  out  1  beq active.
isJump  out  1  jal active.
INT  out  1  PC loads entryPoint.
IRWrite  out  1  fetch strobe, high in FETCH.
PCWrite  out  1  PC update strobe.
ins_done  out  1  one-cycle pulse when an instruction retires.
halted  out  1  sticky high in HALT.
ins_count  out  CNT_W  retired-instruction count; saturates at all ones.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named rst.
- Reset state: while rst=1, every output is 0 (including ins_count, op=000 and halted) and the state goes to ENTRY. Reset mid-instruction aborts it; no write strobe may fire on that edge.
- Output timing: all outputs are registered and decoded from the current state plus the latched IR (opcode, funct3, ins[30]). A change on ins outside the FETCH capture edge has no effect.
- ENTRY: INT=1 and PCWrite=1 for ENTRY_CYCLES cycles, then FETCH.
- FETCH (1 cycle): IRWrite=1; IR <= ins; then DECODE.
- DECODE (1 cycle): classify the opcode.
  - 33h (R-type): funct3 110 -> op 001 (or); 111 -> op 000 (and); 000 -> op 010 (add), or 110 (sub) if ins[30]=1. Other funct3 values are illegal.
  - 13h (I-type): op 010.
  - 03h (lw), 23h (sw): op 010.
  - 63h (beq): op 110.
  - 6Fh (jal).
  - Anything else is illegal: go to HALT, or to the retire path when HALT_ON_ILLEGAL=0.
- Paths (cycles per instruction, counted from FETCH):
  - R-type and I-type: FETCH, DECODE, EXEC, WB = 4.
  - lw: FETCH, DECODE, EXEC, MEM, WB = 5.
  - sw: FETCH, DECODE, EXEC, MEM = 4.
  - beq and jal: FETCH, DECODE, EXEC = 3.
  - Illegal NOP (HALT_ON_ILLEGAL=0): FETCH, DECODE = 2.
- Signal windows:
  - ALUSrc=1 in EXEC/MEM/WB for I-type, lw and sw; 0 for R-type and beq.
  - op is held from DECODE through the last state of the instruction.
  - RegWrite=1 only in WB.
  - MemWrite=1 only in MEM for sw.
  - MemRead=1 in MEM and WB for lw.
  - Mem2Reg=1 in WB for lw only.
  - isBranch=1 in EXEC for beq; isJump=1 in EXEC for jal.
- Retire: the last state of every instruction drives PCWrite=1 and ins_done=1 for exactly 1 cycle. ins_count increments on the following edge.
- MAX_INS: when MAX_INS != 0 and the increment makes ins_count == MAX_INS, the next state is HALT instead of FETCH.
- HALT: halted=1 and all other control outputs are 0 until rst. HALT takes priority over further fetches.
- Mutual exclusion: MemRead and MemWrite are never high together. RegWrite and MemWrite are never high together.

Test Plan:
1. rst=1 for 2 cycles, then release (ENTRY_CYCLES=1) -> all outputs 0 during reset; then INT=PCWrite=1 for exactly 1 cycle; then IRWrite=1 on the next cycle.
2. ins=0020E1B3 (or x3,x1,x2) -> DECODE drives op=001; EXEC drives ALUSrc=0; WB drives RegWrite=1, PCWrite=1, ins_done=1; ins_count 0->1; 4 cycles total.
3. ins=00002283 (lw x5,0(x0)) followed by ins=00502223 (sw x5,4(x0)):
   - lw: ALUSrc=1; MemRead=1 across MEM and WB; Mem2Reg=RegWrite=1 only in WB; 5 cycles.
   - sw: MemWrite=1 for exactly 1 cycle; RegWrite stays 0; 4 cycles.
4. ins=00000463 (beq) -> isBranch=1 and op=110 in EXEC; retires in 3 cycles. ins=0000006F (jal) -> isJump=1 for 1 cycle; retires in 3 cycles.
5. ins=00000037 (lui, illegal) with HALT_ON_ILLEGAL=1 -> halted=1 from the cycle after DECODE; no strobes after that; ins_count unchanged. With HALT_ON_ILLEGAL=0 -> retires in 2 cycles with PCWrite=1.
6. MAX_INS=3, a stream of addi instructions -> ins_count stops at 3 and halted=1. Separately, asserting rst during the MEM state of an sw -> MemWrite stays 0 on that edge and the unit restarts from ENTRY.
